// File: rtl/clk_div_mc.sv
// Multi-channel programmable clock divider. Each channel produces a registered
// square wave and a one-cycle clock enable, with reload only at period boundaries.
module clk_div_mc #(
   parameter int NUM_CH      = 2,
   parameter int DIV_W       = 8,
   parameter int DIV_DEFAULT = 2
) (
   input  logic                    CLK,
   input  logic                    RESETN,
   input  logic                    SRESET,
   input  logic [NUM_CH-1:0]       LOAD,
   input  logic [NUM_CH*DIV_W-1:0] DIV_IN,
   input  logic [NUM_CH-1:0]       BITSLIP,
   output logic [NUM_CH-1:0]       CLK_OUT,
   output logic [NUM_CH-1:0]       CE_OUT,
   output logic [NUM_CH-1:0]       BUSY
);

   localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_DEFAULT);
   localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [DIV_W-1:0] cnt_reg, cnt_next;
         logic [DIV_W-1:0] act_div_reg, act_div_next;
         logic [DIV_W-1:0] pend_div_reg, pend_div_next;
         logic             pend_vld_reg, pend_vld_next;
         logic             start_reg, start_next;
         logic             ce_reg, ce_next;
         logic             clk_out_reg, clk_out_next;
         logic             held, run;
         logic [DIV_W:0]   half;

         always_comb begin
            cnt_next      = '0;
            act_div_next  = act_div_reg;
            pend_div_next = pend_div_reg;
            pend_vld_next = pend_vld_reg;
            start_next    = start_reg;
            held          = 1'b0;
            run           = 1'b1;

            if (act_div_reg == '0) begin
               run = 1'b0;
               if (pend_vld_reg) begin
                  act_div_next  = pend_div_reg;
                  pend_vld_next = 1'b0;
                  start_next    = 1'b1;
               end
            end else if (start_reg) begin
               start_next = 1'b0;
            end else if (BITSLIP[gi]) begin
               cnt_next = cnt_reg;
               held     = 1'b1;
            end else if (cnt_reg >= act_div_reg - ONE) begin
               // Period boundary: the only place a pending divisor may take over.
               if (pend_vld_reg) begin
                  act_div_next  = pend_div_reg;
                  pend_vld_next = 1'b0;
               end
            end else begin
               cnt_next = cnt_reg + ONE;
            end

            // A load on the applying edge becomes the next pending value.
            if (LOAD[gi]) begin
               pend_div_next = DIV_IN[gi*DIV_W +: DIV_W];
               pend_vld_next = 1'b1;
            end

            half         = ({1'b0, act_div_next} + (DIV_W+1)'(1)) >> 1;
            ce_next      = run && !held && (cnt_next == '0) && (act_div_next != '0);
            clk_out_next = run && (act_div_next != '0) && ({1'b0, cnt_next} < half);
            if (run && act_div_next == ONE) begin
               ce_next      = 1'b1;
               clk_out_next = 1'b1;
            end
         end

         always_ff @(posedge CLK or negedge RESETN) begin
            if (!RESETN) begin
               cnt_reg      <= '0;
               act_div_reg  <= DIV_RST;
               pend_div_reg <= '0;
               pend_vld_reg <= 1'b0;
               start_reg    <= 1'b1;
               ce_reg       <= 1'b0;
               clk_out_reg  <= 1'b0;
            end else if (SRESET) begin
               cnt_reg      <= '0;
               act_div_reg  <= DIV_RST;
               pend_div_reg <= '0;
               pend_vld_reg <= 1'b0;
               start_reg    <= 1'b1;
               ce_reg       <= 1'b0;
               clk_out_reg  <= 1'b0;
            end else begin
               cnt_reg      <= cnt_next;
               act_div_reg  <= act_div_next;
               pend_div_reg <= pend_div_next;
               pend_vld_reg <= pend_vld_next;
               start_reg    <= start_next;
               ce_reg       <= ce_next;
               clk_out_reg  <= clk_out_next;
            end
         end

         assign CLK_OUT[gi] = clk_out_reg;
         assign CE_OUT[gi]  = ce_reg;
         assign BUSY[gi]    = pend_vld_reg;
      end
   endgenerate

endmodule

// File: tb/tb_clk_div_mc.sv
// Directed bench for clk_div_mc: reset cadence, reload, bit-slip, stop/restart,
// soft reset and asynchronous reset, with hand-computed per-edge expectations.
module tb_clk_div_mc;

   localparam int NUM_CH = 2;
   localparam int DIV_W  = 8;

   logic                    CLK;
   logic                    RESETN;
   logic                    SRESET;
   logic [NUM_CH-1:0]       LOAD;
   logic [NUM_CH*DIV_W-1:0] DIV_IN;
   logic [NUM_CH-1:0]       BITSLIP;
   logic [NUM_CH-1:0]       CLK_OUT;
   logic [NUM_CH-1:0]       CE_OUT;
   logic [NUM_CH-1:0]       BUSY;

   int checks;
   int passed;

   clk_div_mc #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DIV_DEFAULT(2)) dut (
      .CLK(CLK), .RESETN(RESETN), .SRESET(SRESET), .LOAD(LOAD),
      .DIV_IN(DIV_IN), .BITSLIP(BITSLIP), .CLK_OUT(CLK_OUT),
      .CE_OUT(CE_OUT), .BUSY(BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      LOAD    = '0;
      BITSLIP = '0;
      SRESET  = 1'b0;
      DIV_IN  = '0;
      RESETN  = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RESETN = 1'b1;
   endtask

   // Reset state, then divide-by-2 cadence on both channels from edge 1.
   task automatic test_reset();
      logic [7:0] ce_exp;
      logic [7:0] clk_exp;
      do_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         checks++;
         if ({CLK_OUT[c], CE_OUT[c], BUSY[c]} !== 3'b000)
            $display("FAIL reset_state ch%0d clk/ce/busy=%b%b%b expected 000", c, CLK_OUT[c], CE_OUT[c], BUSY[c]);
         else passed++;
      end
      ce_exp  = 8'b01010101;
      clk_exp = 8'b01010101;
      for (int e = 0; e < 6; e++) begin
         step();
         for (int c = 0; c < NUM_CH; c++) begin
            checks++;
            if (CE_OUT[c] !== ce_exp[e] || CLK_OUT[c] !== clk_exp[e] || BUSY[c] !== 1'b0)
               $display("FAIL reset_div2 ch%0d edge%0d ce/clk/busy=%b%b%b expected %b%b0", c, e+1, CE_OUT[c], CLK_OUT[c], BUSY[c], ce_exp[e], clk_exp[e]);
            else passed++;
         end
         $display("reset_div2 edge%0d CE=%b CLK_OUT=%b BUSY=%b", e+1, CE_OUT, CLK_OUT, BUSY);
      end
   endtask

   // Load 5 mid-period: BUSY until the wrap, then high 3 / low 2.
   task automatic test_load5();
      logic [6:0] ce_exp;
      logic [6:0] clk_exp;
      logic [6:0] busy_exp;
      do_reset();
      step();
      ce_exp   = 7'b1000010;
      clk_exp  = 7'b1001110;
      busy_exp = 7'b0000001;
      for (int e = 0; e < 7; e++) begin
         LOAD[0]          = (e == 0);
         DIV_IN[0 +: DIV_W] = 8'd5;
         step();
         checks++;
         if (CE_OUT[0] !== ce_exp[e] || CLK_OUT[0] !== clk_exp[e] || BUSY[0] !== busy_exp[e])
            $display("FAIL load5 edge%0d ce/clk/busy=%b%b%b expected %b%b%b", e+2, CE_OUT[0], CLK_OUT[0], BUSY[0], ce_exp[e], clk_exp[e], busy_exp[e]);
         else passed++;
         $display("load5 edge%0d CE=%b CLK_OUT=%b BUSY=%b", e+2, CE_OUT[0], CLK_OUT[0], BUSY[0]);
      end
      LOAD = '0;
   endtask

   // Div 4 with bit-slip at cnt=2, then bit-slip on a wrap that has a pending load.
   task automatic test_bitslip();
      logic [6:0] ce_exp;
      logic [6:0] clk_exp;
      logic [3:0] ce2_exp;
      logic [3:0] clk2_exp;
      logic [3:0] busy2_exp;
      do_reset();
      step();
      LOAD[0] = 1'b1; DIV_IN[0 +: DIV_W] = 8'd4;
      step();
      LOAD = '0;
      repeat (3) step();
      ce_exp  = 7'b1000100;
      clk_exp = 7'b1001100;
      for (int e = 0; e < 7; e++) begin
         BITSLIP[0] = (e == 0);
         step();
         checks++;
         if (CE_OUT[0] !== ce_exp[e] || CLK_OUT[0] !== clk_exp[e])
            $display("FAIL bitslip_mid edge%0d ce/clk=%b%b expected %b%b", e+6, CE_OUT[0], CLK_OUT[0], ce_exp[e], clk_exp[e]);
         else passed++;
         $display("bitslip_mid edge%0d CE=%b CLK_OUT=%b", e+6, CE_OUT[0], CLK_OUT[0]);
      end
      BITSLIP = '0;
      step();
      LOAD[0] = 1'b1; DIV_IN[0 +: DIV_W] = 8'd2;
      step();
      LOAD = '0;
      step();
      checks++;
      if (BUSY[0] !== 1'b1)
         $display("FAIL bitslip_busy busy=%b expected 1", BUSY[0]);
      else passed++;
      ce2_exp   = 4'b1010;
      clk2_exp  = 4'b1010;
      busy2_exp = 4'b0001;
      for (int e = 0; e < 4; e++) begin
         BITSLIP[0] = (e == 0);
         step();
         checks++;
         if (CE_OUT[0] !== ce2_exp[e] || CLK_OUT[0] !== clk2_exp[e] || BUSY[0] !== busy2_exp[e])
            $display("FAIL bitslip_wrap edge%0d ce/clk/busy=%b%b%b expected %b%b%b", e+16, CE_OUT[0], CLK_OUT[0], BUSY[0], ce2_exp[e], clk2_exp[e], busy2_exp[e]);
         else passed++;
         $display("bitslip_wrap edge%0d CE=%b CLK_OUT=%b BUSY=%b", e+16, CE_OUT[0], CLK_OUT[0], BUSY[0]);
      end
      BITSLIP = '0;
   endtask

   // Divisor 0 stops the channel; loading 3 restarts it with a CE.
   task automatic test_stop();
      logic [8:0] ce_exp;
      logic [8:0] clk_exp;
      logic [8:0] busy_exp;
      do_reset();
      step();
      LOAD[0] = 1'b1; DIV_IN[0 +: DIV_W] = 8'd0;
      step();
      LOAD = '0;
      ce_exp   = 9'b100100000;
      clk_exp  = 9'b101100000;
      busy_exp = 9'b000001000;
      for (int e = 0; e < 9; e++) begin
         LOAD[0] = (e == 3);
         DIV_IN[0 +: DIV_W] = 8'd3;
         step();
         checks++;
         if (CE_OUT[0] !== ce_exp[e] || CLK_OUT[0] !== clk_exp[e] || BUSY[0] !== busy_exp[e])
            $display("FAIL stop_restart edge%0d ce/clk/busy=%b%b%b expected %b%b%b", e+3, CE_OUT[0], CLK_OUT[0], BUSY[0], ce_exp[e], clk_exp[e], busy_exp[e]);
         else passed++;
         $display("stop_restart edge%0d CE=%b CLK_OUT=%b BUSY=%b", e+3, CE_OUT[0], CLK_OUT[0], BUSY[0]);
      end
      LOAD = '0;
   endtask

   // Soft reset with a pending load: both channels back to div 2, aligned.
   task automatic test_sreset();
      logic [4:0] pat;
      do_reset();
      step();
      LOAD = 2'b11; DIV_IN = {8'd7, 8'd3};
      step();
      LOAD = '0;
      repeat (3) step();
      LOAD = 2'b01; DIV_IN[0 +: DIV_W] = 8'd5;
      step();
      checks++;
      if (BUSY !== 2'b01)
         $display("FAIL sreset_pending busy=%b expected 01", BUSY);
      else passed++;
      LOAD = 2'b10; DIV_IN[DIV_W +: DIV_W] = 8'd9;
      SRESET = 1'b1;
      step();
      LOAD = '0;
      SRESET = 1'b0;
      checks++;
      if ({CLK_OUT, CE_OUT, BUSY} !== 6'b0)
         $display("FAIL sreset_state clk/ce/busy=%b/%b/%b expected 00/00/00", CLK_OUT, CE_OUT, BUSY);
      else passed++;
      pat = 5'b10101;
      for (int e = 0; e < 5; e++) begin
         step();
         checks++;
         if (CE_OUT !== {2{pat[e]}} || CLK_OUT !== {2{pat[e]}} || BUSY !== 2'b00)
            $display("FAIL sreset_restart edge%0d ce=%b clk=%b busy=%b expected ce=clk=%b%b busy=00", e+1, CE_OUT, CLK_OUT, BUSY, pat[e], pat[e]);
         else passed++;
         $display("sreset_restart edge%0d CE=%b CLK_OUT=%b BUSY=%b", e+1, CE_OUT, CLK_OUT, BUSY);
      end
   endtask

   // Async reset between edges while a load is pending.
   task automatic test_async_reset();
      logic [4:0] pat;
      do_reset();
      LOAD[0] = 1'b1; DIV_IN[0 +: DIV_W] = 8'd6;
      step();
      LOAD = '0;
      checks++;
      if ({CLK_OUT[0], CE_OUT[0], BUSY[0]} !== 3'b111)
         $display("FAIL areset_before clk/ce/busy=%b%b%b expected 111", CLK_OUT[0], CE_OUT[0], BUSY[0]);
      else passed++;
      #2;
      RESETN = 1'b0;
      #1;
      checks++;
      if ({CLK_OUT, CE_OUT, BUSY} !== 6'b0)
         $display("FAIL areset_immediate clk/ce/busy=%b/%b/%b expected 00/00/00", CLK_OUT, CE_OUT, BUSY);
      else passed++;
      @(posedge CLK);
      @(negedge CLK);
      RESETN = 1'b1;
      pat = 5'b10101;
      for (int e = 0; e < 5; e++) begin
         step();
         checks++;
         if (CE_OUT[0] !== pat[e] || CLK_OUT[0] !== pat[e] || BUSY[0] !== 1'b0)
            $display("FAIL areset_restart edge%0d ce/clk/busy=%b%b%b expected %b%b0", e+1, CE_OUT[0], CLK_OUT[0], BUSY[0], pat[e], pat[e]);
         else passed++;
         $display("areset_restart edge%0d CE=%b CLK_OUT=%b BUSY=%b", e+1, CE_OUT[0], CLK_OUT[0], BUSY[0]);
      end
   endtask

   initial begin
      checks  = 0;
      passed  = 0;
      RESETN  = 1'b0;
      SRESET  = 1'b0;
      LOAD    = '0;
      BITSLIP = '0;
      DIV_IN  = '0;
      test_reset();
      test_load5();
      test_bitslip();
      test_stop();
      test_sreset();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/clk_div_mc.md
Name: clk_div_mc

Overview:
- Multi-channel, runtime-programmable fabric clock divider. Successor to the fixed divide-by-2 PF_CLK_DIV wrapper.
- Produces a divided square wave and a one-cycle clock-enable per channel from a single source clock.
- Adds per-channel glitch-free divisor reload, bit-slip phase adjust and synchronous soft reset.
- Sits beside the video/H264 clock trees. Feeds CE-based downstream logic (pixel/line rate enables) instead of extra global clocks.

Parameters:
- NUM_CH, 2, number of independent divider channels (1..8).
- DIV_W, 8, divisor width in bits (2..16).
- DIV_DEFAULT, 2, divisor loaded by reset/SRESET on all channels (1..2^DIV_W-1).

Ports:
- CLK  in  1  source clock; all logic on rising edge.
- RESETN  in  1  asynchronous active-low reset.
- SRESET  in  1  synchronous soft reset, active-high, all channels.
- LOAD  in  NUM_CH  per-channel strobe; samples that channel's DIV_IN slice.
- DIV_IN  in  NUM_CH*DIV_W  divisor per channel; channel c uses bits [c*DIV_W +: DIV_W].
- BITSLIP  in  NUM_CH  per-channel pulse; retards phase by one CLK.
- CLK_OUT  out  NUM_CH  divided square wave, registered.
- CE_OUT  out  NUM_CH  one-CLK pulse at start of each divided period, registered.
- BUSY  out  NUM_CH  high while a loaded divisor is pending application.

Behaviour:
- Per channel state: cnt[DIV_W], act_div[DIV_W], pend_div[DIV_W], pend_vld, start. H = (act_div+1)>>1, so the high phase is the longer one for odd divisors.
- RESETN low (async) or SRESET high (sync, priority over all other inputs):
  - cnt=0, act_div=DIV_DEFAULT, pend_vld=0, start=1.
  - CLK_OUT=0, CE_OUT=0, BUSY=0.
- Each edge, per channel, compute cnt_next. Highest priority first:
  - act_div==0: channel stopped. cnt_next=0, outputs 0. If pend_vld, apply pending (act_div<=pend_div, pend_vld<=0) and set start=1.
  - start==1: cnt_next=0, start<=0.
  - BITSLIP==1: cnt_next=cnt (hold). This extends the current period by one CLK. No wrap and no pending apply on this edge.
  - cnt>=act_div-1: wrap, cnt_next=0. If pend_vld, act_div<=pend_div and pend_vld<=0 on this same edge.
  - Otherwise: cnt_next=cnt+1.
- Outputs registered from cnt_next and the act_div in effect after the edge:
  - CE_OUT <= (cnt_next==0) and not held and div!=0.
  - CLK_OUT <= (cnt_next < H).
  - act_div==1: CLK_OUT and CE_OUT both constant 1 while running.
- LOAD==1: pend_div<=DIV_IN slice, pend_vld<=1, BUSY<=1 next cycle. A later LOAD before apply overwrites pend_div (last wins).
- LOAD on the same edge as a wrap: the old pending value, if any, is applied. The new value becomes pending and applies at the next wrap.
- Divisor changes take effect only at period boundaries, so there is never a runt pulse on CLK_OUT.
- Latency: first CE_OUT is high in the first cycle after the first edge following reset release.
- Channels are fully independent. No cross-channel phase alignment except via common reset/SRESET.
- cnt_next never exceeds act_div-1 after a wrap. The >= compare guards against out-of-range cnt.

Test Plan:
- Reset, DIV_DEFAULT=2, no other stimulus -> CE_OUT pulses every 2nd CLK starting edge 1. CLK_OUT toggles 1,0,1,0. BUSY=0.
- LOAD ch0 DIV_IN=5 mid-period -> BUSY=1 until the next wrap. Then period=5: CLK_OUT high 3/low 2, CE every 5 CLK. No short pulse at the changeover.
- DIV=4 running, BITSLIP pulse at cnt=2 -> that period is 5 CLK (cnt 0,1,2,2,3), then 4-CLK periods resume. BITSLIP on the wrap cycle defers the wrap and any pending load by one CLK.
- LOAD DIV_IN=0 -> after the wrap, CLK_OUT=CE_OUT=0 steady. Then LOAD DIV_IN=3 -> restarts next CLK with CE=1, period 3.
- Ch0 DIV=3, ch1 DIV=7, SRESET pulse mid-period -> both channels return to DIV_DEFAULT=2, pending loads cleared, CE aligned on the edge after SRESET deasserts.
- RESETN asserted asynchronously between edges during a pending load -> outputs go 0 immediately, BUSY=0. Restart matches scenario 1.
